uart_tx_axis: RTL and testbench

//  UART transmitter that drains a valid/ready byte stream, e.g. the read side of the sync FIFO.

---
 rtl/uart_tx_axis_pkg.sv | 27 ++
 rtl/uart_tx_axis_baud_gen.sv | 31 +++
 rtl/uart_tx_axis.sv | 119 +++++++++++
 tb/tb_uart_tx_axis.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_axis_pkg.sv
// Shared types and helpers for the UART transmit path (state encoding, baud divisor, parity).
package uart_tx_axis_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  // Truncating divide; the caller guarantees the result is at least 2.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  // Caller zero-extends narrower words, which leaves the reduction unchanged.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_axis_baud_gen.sv
// Bit-period timer: counts 0..BaudDiv-1 while enabled and flags the last cycle of each bit.
module uart_tx_axis_baud_gen
  import uart_tx_axis_pkg::*;
#(
  parameter int unsigned BaudDiv = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic bit_end_o
);

  localparam int unsigned    CntW   = cnt_width(BaudDiv);
  localparam logic [CntW-1:0] CntMax = CntW'(BaudDiv - 1);

  logic [CntW-1:0] cnt_q;

  assign bit_end_o = en_i & (cnt_q == CntMax);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= bit_end_o ? '0 : cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_axis.sv
// UART transmitter draining a valid/ready byte stream; one frame per accepted word.
module uart_tx_axis
  import uart_tx_axis_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_valid_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ready_o,
  output logic                 uart_txd_o,
  output logic                 busy_o
);

  localparam int unsigned BaudDiv  = baud_div(CLK_FREQ, BAUD_RATE);
  localparam logic [2:0]  LastBit  = 3'(DATA_BITS - 1);
  localparam logic        LastStop = 1'(STOP_BITS - 1);

  tx_state_e            state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [2:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 parity_q;
  logic                 txd_q;
  logic                 handshake;
  logic                 bit_end;

  // Ready depends only on state so upstream can never see a valid->ready loop.
  assign tx_ready_o = (state_q == StIdle);
  assign busy_o     = (state_q != StIdle);
  assign handshake  = tx_valid_i & tx_ready_o;
  assign uart_txd_o = txd_q;

  uart_tx_axis_baud_gen #(
    .BaudDiv (BaudDiv)
  ) u_baud_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (handshake),
    .en_i      (busy_o),
    .bit_end_o (bit_end)
  );

  // txd_q is loaded with the level of the upcoming bit on each transition edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (handshake) begin
            state_q    <= StStart;
            txd_q      <= 1'b0;
            shreg_q    <= tx_data_i;
            parity_q   <= parity_bit(8'(tx_data_i), PARITY_ODD != 0);
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q <= StData;
            txd_q   <= shreg_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            shreg_q <= shreg_q >> 1;
            if (bit_cnt_q == LastBit) begin
              if (PARITY_EN != 0) begin
                state_q <= StParity;
                txd_q   <= parity_q;
              end else begin
                state_q <= StStop;
                txd_q   <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              txd_q     <= shreg_q[1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q <= StStop;
            txd_q   <= 1'b1;
          end
        end
        StStop: begin
          txd_q <= 1'b1;
          if (bit_end) begin
            if (stop_cnt_q == LastStop) begin
              state_q <= StIdle;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_axis.sv
// Directed bench for uart_tx_axis: 8N1, 8E1, 8O1 and 7N2 instances at BAUD_DIV=10.
module tb_uart_tx_axis;

  logic       clk;
  logic       rst_n;
  logic [3:0] valid;
  logic [7:0] data [4];
  logic [3:0] txd;
  logic [3:0] rdy;
  logic [3:0] bsy;
  int         n_pass;
  int         n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_axis #(
    .CLK_FREQ (50_000_000), .BAUD_RATE (5_000_000), .DATA_BITS (8),
    .PARITY_EN (0), .PARITY_ODD (0), .STOP_BITS (1)
  ) u_8n1 (
    .clk_i (clk), .rst_ni (rst_n), .tx_valid_i (valid[0]), .tx_data_i (data[0]),
    .tx_ready_o (rdy[0]), .uart_txd_o (txd[0]), .busy_o (bsy[0])
  );

  uart_tx_axis #(
    .CLK_FREQ (50_000_000), .BAUD_RATE (5_000_000), .DATA_BITS (8),
    .PARITY_EN (1), .PARITY_ODD (0), .STOP_BITS (1)
  ) u_8e1 (
    .clk_i (clk), .rst_ni (rst_n), .tx_valid_i (valid[1]), .tx_data_i (data[1]),
    .tx_ready_o (rdy[1]), .uart_txd_o (txd[1]), .busy_o (bsy[1])
  );

  uart_tx_axis #(
    .CLK_FREQ (50_000_000), .BAUD_RATE (5_000_000), .DATA_BITS (8),
    .PARITY_EN (1), .PARITY_ODD (1), .STOP_BITS (1)
  ) u_8o1 (
    .clk_i (clk), .rst_ni (rst_n), .tx_valid_i (valid[2]), .tx_data_i (data[2]),
    .tx_ready_o (rdy[2]), .uart_txd_o (txd[2]), .busy_o (bsy[2])
  );

  uart_tx_axis #(
    .CLK_FREQ (50_000_000), .BAUD_RATE (5_000_000), .DATA_BITS (7),
    .PARITY_EN (0), .PARITY_ODD (0), .STOP_BITS (2)
  ) u_7n2 (
    .clk_i (clk), .rst_ni (rst_n), .tx_valid_i (valid[3]), .tx_data_i (data[3][6:0]),
    .tx_ready_o (rdy[3]), .uart_txd_o (txd[3]), .busy_o (bsy[3])
  );

  // Frame bits in transmit order (bit 0 first), each stretched to 10 clk; idle high beyond.
  function automatic logic [127:0] expand(input logic [12:0] bits, input int nbits);
    logic [127:0] r;
    r = '1;
    for (int c = 0; c < nbits * 10; c++) r[c] = bits[c / 10];
    return r;
  endfunction

  task automatic launch(input int inst, input logic [7:0] d);
    @(negedge clk);
    valid[inst] = 1'b1;
    data[inst]  = d;
    @(posedge clk);
    #1;
    valid[inst] = 1'b0;
  endtask

  // Records txd once per cycle starting with the cycle right after the handshake edge.
  task automatic capture(input int inst, input int n, output logic [127:0] wave,
                         output int rdy_low, output int bsy_hi);
    wave    = '1;
    rdy_low = 0;
    bsy_hi  = 0;
    for (int c = 0; c < n; c++) begin
      wave[c] = txd[inst];
      if (!rdy[inst]) rdy_low++;
      if (bsy[inst]) bsy_hi++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    n_total++;
    if (txd !== 4'hF) $display("FAIL reset_txd: got %b want 1111", txd);
    else n_pass++;
    n_total++;
    if (rdy !== 4'hF) $display("FAIL reset_ready: got %b want 1111", rdy);
    else n_pass++;
    n_total++;
    if (bsy !== 4'h0) $display("FAIL reset_busy: got %b want 0000", bsy);
    else n_pass++;
  endtask

  task automatic test_8n1();
    logic [127:0] w;
    logic [127:0] e;
    int rl, bh;
    e = expand(13'b1010101010, 10);
    launch(0, 8'h55);
    capture(0, 100, w, rl, bh);
    n_total++;
    if (w !== e) $display("FAIL 8n1_wave: got %h want %h", w, e);
    else n_pass++;
    n_total++;
    if (rl !== 100) $display("FAIL 8n1_ready_low: got %0d want 100", rl);
    else n_pass++;
    n_total++;
    if (bh !== 100) $display("FAIL 8n1_busy_high: got %0d want 100", bh);
    else n_pass++;
    n_total++;
    if ({txd[0], rdy[0], bsy[0]} !== 3'b110)
      $display("FAIL 8n1_idle: got %b want 110", {txd[0], rdy[0], bsy[0]});
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [127:0] w;
    logic [127:0] e;
    int rl, bh;
    e = expand(13'b11000001110, 11);
    launch(1, 8'h07);
    capture(1, 110, w, rl, bh);
    n_total++;
    if (w !== e) $display("FAIL even_parity_wave: got %h want %h", w, e);
    else n_pass++;
    n_total++;
    if (rl !== 110 || rdy[1] !== 1'b1)
      $display("FAIL even_frame_len: got %0d/%b want 110/1", rl, rdy[1]);
    else n_pass++;
    e = expand(13'b11000000000, 11);
    launch(2, 8'h00);
    capture(2, 110, w, rl, bh);
    n_total++;
    if (w !== e) $display("FAIL odd_parity_wave: got %h want %h", w, e);
    else n_pass++;
    n_total++;
    if (bh !== 110 || bsy[2] !== 1'b0)
      $display("FAIL odd_frame_len: got %0d/%b want 110/0", bh, bsy[2]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] w1, w2;
    logic [127:0] e1, e2;
    int rl1, bh1, rl2, bh2;
    e1 = expand(13'b1101001010, 10);
    e2 = expand(13'b1001111000, 10);
    @(negedge clk);
    valid[0] = 1'b1;
    data[0]  = 8'hA5;
    @(posedge clk);
    #1;
    data[0] = 8'h3C;
    capture(0, 100, w1, rl1, bh1);
    n_total++;
    if ({txd[0], rdy[0]} !== 2'b11)
      $display("FAIL b2b_gap: got txd/ready %b want 11", {txd[0], rdy[0]});
    else n_pass++;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    capture(0, 100, w2, rl2, bh2);
    n_total++;
    if (w1 !== e1) $display("FAIL b2b_first: got %h want %h", w1, e1);
    else n_pass++;
    n_total++;
    if (w2 !== e2) $display("FAIL b2b_second: got %h want %h", w2, e2);
    else n_pass++;
    n_total++;
    if (rl1 !== 100 || rl2 !== 100)
      $display("FAIL b2b_ready_low: got %0d,%0d want 100,100", rl1, rl2);
    else n_pass++;
    n_total++;
    if (rdy[0] !== 1'b1) $display("FAIL b2b_end_ready: got %b want 1", rdy[0]);
    else n_pass++;
  endtask

  task automatic test_7n2();
    logic [127:0] w;
    logic [127:0] e;
    int rl, bh;
    e = expand(13'b1111111110, 10);
    launch(3, 8'h7F);
    capture(3, 100, w, rl, bh);
    n_total++;
    if (w !== e) $display("FAIL 7n2_wave: got %h want %h", w, e);
    else n_pass++;
    n_total++;
    if (rl !== 100 || bh !== 100)
      $display("FAIL 7n2_len: got %0d,%0d want 100,100", rl, bh);
    else n_pass++;
    n_total++;
    if ({txd[3], rdy[3], bsy[3]} !== 3'b110)
      $display("FAIL 7n2_idle: got %b want 110", {txd[3], rdy[3], bsy[3]});
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [127:0] w;
    logic [127:0] e;
    int rl, bh;
    launch(0, 8'hF0);
    capture(0, 45, w, rl, bh);
    n_total++;
    if (w[44:0] !== 45'd0) $display("FAIL midrst_pre: got %h want 0", w[44:0]);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({txd[0], rdy[0], bsy[0]} !== 3'b110)
      $display("FAIL midrst_async: got %b want 110", {txd[0], rdy[0], bsy[0]});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if ({txd[0], rdy[0], bsy[0]} !== 3'b110)
      $display("FAIL midrst_release: got %b want 110", {txd[0], rdy[0], bsy[0]});
    else n_pass++;
    e = expand(13'b1000100100, 10);
    launch(0, 8'h12);
    capture(0, 100, w, rl, bh);
    n_total++;
    if (w !== e) $display("FAIL midrst_next: got %h want %h", w, e);
    else n_pass++;
  endtask

  task automatic test_valid_toggle();
    logic [127:0] w;
    logic [127:0] e;
    int rl, bh;
    e = expand(13'b1100101100, 10);
    launch(0, 8'h96);
    fork
      capture(0, 100, w, rl, bh);
      begin
        for (int i = 0; i < 99; i++) begin
          @(negedge clk);
          valid[0] = 1'($urandom);
          data[0]  = 8'($urandom);
        end
        @(negedge clk);
        valid[0] = 1'b0;
      end
    join
    n_total++;
    if (w !== e) $display("FAIL toggle_wave: got %h want %h", w, e);
    else n_pass++;
    n_total++;
    if (rl !== 100) $display("FAIL toggle_ready_low: got %0d want 100", rl);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bsy[0] !== 1'b0) $display("FAIL toggle_no_accept: got busy %b want 0", bsy[0]);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    logic [127:0] w;
    logic [7:0]   d;
    logic [7:0]   got;
    int rl, bh;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      launch(0, d);
      capture(0, 100, w, rl, bh);
      for (int j = 0; j < 8; j++) got[j] = w[(j + 1) * 10 + 5];
      n_total++;
      if (got !== d || w[5] !== 1'b0 || w[95] !== 1'b1)
        $display("FAIL stream_byte%0d: got %h start %b stop %b want %h 0 1",
                 i, got, w[5], w[95], d);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    valid   = 4'h0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_8n1();
    test_parity();
    test_back_to_back();
    test_7n2();
    test_reset_mid_frame();
    test_valid_toggle();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
